// File: rtl/wb_testram.sv
// Wishbone data RAM for the Moxie SoC: big-endian, byte/halfword/word access, one-cycle registered ack.
// Define WB_TESTRAM_BOUNDS_EN to add wb_err_o and reject addresses outside BASE_ADDR's window.
module wb_testram #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0400_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_adr_i,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o
`ifdef WB_TESTRAM_BOUNDS_EN
    ,
    output logic        wb_err_o
`endif
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    logic [7:0]            mem [4][DEPTH];
    logic [ADDR_WIDTH-3:0] idx;
    logic [1:0]            ofs;
    size_e                 size;
    logic                  busy;
    logic                  in_range;
    logic                  req;
    logic                  wr_en;
    logic [3:0]            lane_we;
    logic [0:3][7:0]       lane_wd;
    logic [0:3][7:0]       rd_lanes;
    logic [31:0]           rd_data;

    assign idx  = wb_adr_i[ADDR_WIDTH-1:2];
    assign ofs  = wb_adr_i[1:0];
    assign size = (wb_sel_i == 2'b00) ? SZ_BYTE : (wb_sel_i == 2'b01) ? SZ_HALF : SZ_WORD;

`ifdef WB_TESTRAM_BOUNDS_EN
    assign busy     = wb_ack_o | wb_err_o;
    assign in_range = (wb_adr_i[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
`else
    logic unused_upper;
    assign unused_upper = ^{wb_adr_i[31:ADDR_WIDTH], BASE_ADDR};
    assign busy         = wb_ack_o;
    assign in_range     = 1'b1;
`endif

    // The idle cycle after every ack/err falls out of gating the request with busy.
    assign req   = wb_cyc_i & wb_stb_i & ~busy;
    // rst_i gates the write so a request whose edge lands inside reset commits nothing.
    assign wr_en = req & in_range & wb_we_i & rst_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        lane_we = '0;
        lane_wd = wb_dat_i;
        unique case (size)
            SZ_BYTE: begin
                lane_we[ofs] = 1'b1;
                lane_wd[ofs] = wb_dat_i[7:0];
            end
            SZ_HALF: begin
                lane_we[{ofs[1], 1'b0}] = 1'b1;
                lane_we[{ofs[1], 1'b1}] = 1'b1;
                lane_wd[{ofs[1], 1'b0}] = wb_dat_i[15:8];
                lane_wd[{ofs[1], 1'b1}] = wb_dat_i[7:0];
            end
            default: lane_we = 4'b1111;
        endcase
    end

    // NOTE: the storage array has no reset; clearing it would turn the RAM into a register file.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < 4; l++) begin
            if (wr_en && lane_we[l]) begin
                mem[l][idx] <= lane_wd[l];
            end
        end
    end

    always_comb begin
        for (int l = 0; l < 4; l++) begin
            rd_lanes[l] = mem[l][idx];
        end
        unique case (size)
            SZ_BYTE: rd_data = {24'b0, rd_lanes[ofs]};
            SZ_HALF: rd_data = {16'b0, rd_lanes[{ofs[1], 1'b0}], rd_lanes[{ofs[1], 1'b1}]};
            default: rd_data = rd_lanes;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
`ifdef WB_TESTRAM_BOUNDS_EN
            wb_err_o <= 1'b0;
`endif
        end else begin
            wb_ack_o <= req & in_range;
`ifdef WB_TESTRAM_BOUNDS_EN
            wb_err_o <= req & ~in_range;
`endif
            if (req && in_range && !wb_we_i) begin
                wb_dat_o <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_testram.sv
// Self-checking bench for wb_testram: directed steps plus random traffic against a byte-array model.
// Define WB_TESTRAM_BOUNDS_EN to also exercise the out-of-window error path.
module tb_wb_testram;

    localparam logic [31:0] BASE = 32'h0400_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_adr_i = '0;
    logic [1:0]  wb_sel_i = '0;
    logic        wb_we_i  = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_ack_o;
`ifdef WB_TESTRAM_BOUNDS_EN
    logic        wb_err_o;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: a flat 4 KiB byte array, address 0 is the first (most significant) byte.
    logic [7:0] ref_mem [4096];

    wb_testram dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_adr_i(wb_adr_i),
        .wb_sel_i(wb_sel_i),
        .wb_we_i (wb_we_i),
        .wb_cyc_i(wb_cyc_i),
        .wb_stb_i(wb_stb_i),
        .wb_ack_o(wb_ack_o)
`ifdef WB_TESTRAM_BOUNDS_EN
        ,
        .wb_err_o(wb_err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] sel);
        int o;
        o = int'(a[11:0]);
        if (sel == 2'b00) return {24'b0, ref_mem[o]};
        if (sel == 2'b01) begin
            o = o & ~1;
            return {16'b0, ref_mem[o], ref_mem[o+1]};
        end
        o = o & ~3;
        return {ref_mem[o], ref_mem[o+1], ref_mem[o+2], ref_mem[o+3]};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [1:0] sel, input logic [31:0] d);
        int o;
        o = int'(a[11:0]);
        if (sel == 2'b00) begin
            ref_mem[o] = d[7:0];
        end else if (sel == 2'b01) begin
            o = o & ~1;
            ref_mem[o]   = d[15:8];
            ref_mem[o+1] = d[7:0];
        end else begin
            o = o & ~3;
            ref_mem[o]   = d[31:24];
            ref_mem[o+1] = d[23:16];
            ref_mem[o+2] = d[15:8];
            ref_mem[o+3] = d[7:0];
        end
    endtask

    // One bus transfer; waits at most 4 cycles for ack/err and checks it arrived after exactly one.
    task automatic xfer(input logic [31:0] adr, input logic [1:0] sel, input logic we,
                        input logic [31:0] wdat, output logic [31:0] rdat,
                        output logic got_ack, output logic got_err);
        int   n;
        logic term;
        @(negedge clk_i);
        wb_adr_i = adr;
        wb_sel_i = sel;
        wb_we_i  = we;
        wb_dat_i = wdat;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        n    = 0;
        term = 1'b0;
        while (!term && n < 4) begin
            @(negedge clk_i);
            n++;
`ifdef WB_TESTRAM_BOUNDS_EN
            term = wb_ack_o | wb_err_o;
            got_err = wb_err_o;
`else
            term = wb_ack_o;
            got_err = 1'b0;
`endif
        end
        got_ack  = wb_ack_o;
        rdat     = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        check("term_latency", n, 1);
    endtask

    task automatic do_write(input logic [31:0] adr, input logic [1:0] sel, input logic [31:0] d);
        logic [31:0] r;
        logic a, e;
        xfer(adr, sel, 1'b1, d, r, a, e);
        check("wr_ack", {31'b0, a}, 32'd1);
        model_write(adr, sel, d);
    endtask

    task automatic do_read(input logic [31:0] adr, input logic [1:0] sel, input string tag,
                           output logic [31:0] rdat);
        logic a, e;
        xfer(adr, sel, 1'b0, '0, rdat, a, e);
        check("rd_ack", {31'b0, a}, 32'd1);
        check(tag, rdat, model_read(adr, sel));
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] last_rd;
        logic        ga, ge;

        // Reset held with a live request: no ack, zero data.
        wb_adr_i = BASE;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("first_ack", {31'b0, wb_ack_o}, 32'd1);
        @(negedge clk_i);
        check("ack_idle", {31'b0, wb_ack_o}, 32'd0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;

        // Give every word a known value so later reads never see X.
        for (int i = 0; i < 1024; i++) begin
            do_write(BASE + 32'(i * 4), 2'b10, $urandom());
        end

        do_write(BASE + 32'h10, 2'b10, 32'hDEAD_BEEF);
        do_read(BASE + 32'h10, 2'b10, "word_rd", rd);
        check("word_const", rd, 32'hDEAD_BEEF);
        for (int b = 0; b < 4; b++) begin
            do_read(BASE + 32'h10 + 32'(b), 2'b00, "byte_rd", rd);
        end
        check("byte3_const", rd, 32'h0000_00EF);

        do_write(BASE + 32'h11, 2'b00, 32'hFFFF_FF5A);
        do_write(BASE + 32'h12, 2'b01, 32'hFFFF_1234);
        do_read(BASE + 32'h10, 2'b10, "mixed_word", rd);
        check("mixed_const", rd, 32'hDE5A_1234);
        do_read(BASE + 32'h10, 2'b01, "half_rd", rd);
        check("half_const", rd, 32'h0000_DE5A);

        do_write(BASE + 32'h40, 2'b10, 32'h0BAD_F00D);
        check("wr_keeps_dat", wb_dat_o, 32'h0000_DE5A);

        // stb held high across four reads: ack every other cycle.
        @(negedge clk_i);
        wb_adr_i = BASE + 32'h10;
        wb_sel_i = 2'b10;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        check("hs_0", {31'b0, wb_ack_o}, 32'd0);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk_i);
            check("hs_pattern", {31'b0, wb_ack_o}, 32'(k % 2));
        end
        check("hs_dat", wb_dat_o, 32'hDE5A_1234);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;

        // stb without cyc must neither ack nor write.
        @(negedge clk_i);
        wb_we_i  = 1'b1;
        wb_dat_i = 32'h0;
        wb_stb_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            check("nocyc_ack", {31'b0, wb_ack_o}, 32'd0);
        end
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        do_read(BASE + 32'h10, 2'b10, "nocyc_nowrite", rd);

        do_write(BASE + 32'h13, 2'b10, 32'hCAFE_F00D);
        do_read(BASE + 32'h10, 2'b10, "unaligned_word", rd);
        check("unaligned_const", rd, 32'hCAFE_F00D);

`ifndef WB_TESTRAM_BOUNDS_EN
        do_write(32'h0400_1000, 2'b10, 32'h1357_9BDF);
        do_read(BASE, 2'b10, "alias_rd", rd);
        check("alias_const", rd, 32'h1357_9BDF);
`endif

        // A write whose clock edge falls inside reset must not land.
        @(negedge clk_i);
        wb_adr_i = BASE + 32'h20;
        wb_sel_i = 2'b10;
        wb_we_i  = 1'b1;
        wb_dat_i = ~model_read(BASE + 32'h20, 2'b10);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        check("preempt_ack", {31'b0, wb_ack_o}, 32'd0);
        check("preempt_dat", wb_dat_o, 32'd0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        rst_i    = 1'b1;
        do_read(BASE + 32'h20, 2'b10, "preempt_nowrite", last_rd);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [1:0]  s;
            a = BASE | 32'($urandom_range(0, 4095));
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, s, $urandom());
                check("rand_dat_hold", wb_dat_o, last_rd);
            end else begin
                do_read(a, s, "rand_rd", last_rd);
            end
        end

`ifdef WB_TESTRAM_BOUNDS_EN
        xfer(32'h0500_0000, 2'b10, 1'b1, 32'hFFFF_FFFF, rd, ga, ge);
        check("oob_err", {31'b0, ge}, 32'd1);
        check("oob_ack", {31'b0, ga}, 32'd0);
        check("oob_dat_hold", rd, last_rd);
        do_read(BASE, 2'b10, "oob_nowrite", rd);
`else
        xfer(32'h0500_0000, 2'b10, 1'b0, 32'h0, rd, ga, ge);
        check("upper_ignored_ack", {31'b0, ga}, 32'd1);
        check("upper_ignored_rd", rd, model_read(32'h0500_0000, 2'b10));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
